// File: rtl/alu_op_sequencer.sv
// Command sequencer feeding the 8-bit add/sub/rotate result register.
// Queued commands are expanded into per-cycle operations; idle cycles re-add res + 0 so the result holds.
//
// state | meaning
// IDLE  | hold pattern (ADD res + 0), waiting for a queued command
// ARITH | ADD/SUB presented for one cycle with the stored operands
// ROT   | rotate presented while the step down-counter runs to zero
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [CNT_W-1:0] cmd_rep,
  input  logic [7:0]       res,
  output logic [2:0]       Control,
  output logic [7:0]       Input_1,
  output logic [7:0]       Input_2,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 2 + 8 + 8 + CNT_W;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARITH = 2'd1,
    S_ROT   = 2'd2
  } state_t;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full, empty, push, pop, load;

  logic [ENT_W-1:0] head;
  logic [1:0]       h_op;
  logic [7:0]       h_a, h_b;
  logic [CNT_W-1:0] h_rep;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign busy      = (state_q != S_IDLE) || !empty;

  assign head  = mem_q[rd_ptr_q];
  assign h_op  = head[ENT_W-1 -: 2];
  assign h_a   = head[ENT_W-3 -: 8];
  assign h_b   = head[ENT_W-11 -: 8];
  assign h_rep = head[CNT_W-1:0];

  // Storage is not reset: entries are only read once counted valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_rep};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        load = !empty;
      end
      S_ARITH: begin
        done = 1'b1;
        load = !empty;
        if (empty) state_d = S_IDLE;
      end
      S_ROT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          done = 1'b1;
          load = !empty;
          if (empty) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A finishing command chains straight into the next one, no hold cycle.
    if (load) begin
      op_d    = h_op;
      a_d     = h_a;
      b_d     = h_b;
      cnt_d   = (h_rep == '0) ? '0 : h_rep - CNT_W'(1);
      state_d = h_op[1] ? S_ROT : S_ARITH;
    end
  end

  assign pop = load;

  always_comb begin
    Control = 3'b110;
    Input_1 = res;
    Input_2 = 8'h00;
    case (state_q)
      S_ARITH: begin
        Control = op_q[0] ? 3'b100 : 3'b110;
        Input_1 = a_q;
        Input_2 = b_q;
      end
      S_ROT: begin
        Control = op_q[0] ? 3'b000 : 3'b001;
        Input_1 = 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the downstream result register.
module tb_alu_op_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_a = 8'h00;
  logic [7:0] cmd_b = 8'h00;
  logic [3:0] cmd_rep = 4'h0;
  logic [7:0] res;
  logic [2:0] Control;
  logic [7:0] Input_1, Input_2;
  logic       busy, done;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  logic       done_prev = 1'b0;
  logic [7:0] res_log [$];
  int         done_cyc [$];

  alu_op_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_rep   (cmd_rep),
    .res       (res),
    .Control   (Control),
    .Input_1   (Input_1),
    .Input_2   (Input_2),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  // Downstream result register: 110 add, 100 sub, 001 rotl, 000 rotr.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) res <= 8'h00;
    else begin
      case (Control)
        3'b110:  res <= Input_1 + Input_2;
        3'b100:  res <= Input_1 - Input_2;
        3'b001:  res <= {res[6:0], res[7]};
        3'b000:  res <= {res[0], res[7:1]};
        default: res <= res;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    cyc++;
    if (done_prev) res_log.push_back(res);
    if (done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    done_prev = done;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] rep);
    int g;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_rep = rep;
    cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 50) begin step(); g++; end
    if (g >= 50) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, g, low_cnt;
    logic [7:0] a_tab [6];
    logic [7:0] exp_burst [7];
    a_tab     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_burst = '{8'h80, 8'h11, 8'h23, 8'h35, 8'h47, 8'h59, 8'h6B};

    #1 RST = 1'b1;
    #2;
    chk("rst_control", 32'(Control), 32'h6);
    chk("rst_input1",  32'(Input_1), 32'h00);
    chk("rst_input2",  32'(Input_2), 32'h00);
    chk("rst_ready",   32'(cmd_ready), 32'd1);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_done",    32'(done), 32'd0);
    step();
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_res",     32'(res), 32'h00);
      chk("idle_control", 32'(Control), 32'h6);
      chk("idle_input2",  32'(Input_2), 32'h00);
      chk("idle_busy",    32'(busy), 32'd0);
    end

    // ADD 0x80 + 0x01
    d0 = done_cnt;
    send(2'b00, 8'h80, 8'h01, 4'h0);
    chk("add_wait_done", 32'(done), 32'd0);
    step();
    chk("add_done",    32'(done), 32'd1);
    chk("add_control", 32'(Control), 32'h6);
    chk("add_input1",  32'(Input_1), 32'h80);
    chk("add_input2",  32'(Input_2), 32'h01);
    step();
    chk("add_res", 32'(res), 32'h81);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("add_hold", 32'(res), 32'h81);
    end
    chk("add_done_pulses", 32'(done_cnt - d0), 32'd1);

    // SUB with and without wrap
    send(2'b01, 8'h80, 8'h01, 4'h0);
    step();
    chk("sub_control", 32'(Control), 32'h4);
    step();
    chk("sub_res", 32'(res), 32'h7F);
    send(2'b01, 8'h00, 8'h01, 4'h0);
    step(); step();
    chk("sub_wrap_res", 32'(res), 32'hFF);

    // ADD then ROTL rep=3, back to back
    d0 = done_cnt;
    send(2'b00, 8'h18, 8'h04, 4'h0);
    send(2'b10, 8'h00, 8'h00, 4'h3);
    step();
    chk("rotl_pre_res",  32'(res), 32'h1C);
    chk("rotl_control",  32'(Control), 32'h1);
    chk("rotl_input1",   32'(Input_1), 32'h00);
    step();
    chk("rotl_res1", 32'(res), 32'h38);
    step();
    chk("rotl_res2", 32'(res), 32'h70);
    step();
    chk("rotl_res3", 32'(res), 32'hE0);
    step();
    chk("rotl_hold", 32'(res), 32'hE0);
    chk("rotl_busy", 32'(busy), 32'd0);
    chk("rotl_done_pulses", 32'(done_cnt - d0), 32'd2);

    // ADD then ROTR rep=0 (one step)
    send(2'b00, 8'h01, 8'h00, 4'h0);
    send(2'b11, 8'h00, 8'h00, 4'h0);
    step();
    chk("rotr_pre_res", 32'(res), 32'h01);
    chk("rotr_control", 32'(Control), 32'h0);
    step();
    chk("rotr_res", 32'(res), 32'h80);
    step();
    chk("rotr_hold", 32'(res), 32'h80);

    // Long ROTL fills the FIFO behind it while six ADDs stream in
    res_log.delete();
    done_cyc.delete();
    low_cnt = 0;
    send(2'b10, 8'h00, 8'h00, 4'h8);
    for (int i = 0; i < 6; i++) begin
      cmd_op = 2'b00; cmd_a = a_tab[i]; cmd_b = 8'(i); cmd_rep = 4'h0;
      cmd_valid = 1'b1;
      g = 0;
      while (!cmd_ready && g < 50) begin step(); g++; end
      low_cnt += g;
      step();
    end
    cmd_valid = 1'b0;
    chk("burst_ready_low_cycles", 32'(low_cnt), 32'd5);
    g = 0;
    while (done_cyc.size() < 7 && g < 60) begin step(); g++; end
    chk("burst_done_count", 32'(done_cyc.size()), 32'd7);
    chk("burst_busy_last", 32'(busy), 32'd1);
    step();
    chk("burst_busy_fall", 32'(busy), 32'd0);
    chk("burst_res_count", 32'(res_log.size()), 32'd7);
    for (int k = 0; k < 7; k++)
      if (k < res_log.size()) chk("burst_res", 32'(res_log[k]), 32'(exp_burst[k]));
    for (int k = 1; k < 7; k++)
      if (k < done_cyc.size()) chk("burst_gap", 32'(done_cyc[k] - done_cyc[k-1]), 32'd1);

    // Reset during a long rotate with two commands queued
    send(2'b10, 8'h00, 8'h00, 4'h8);
    send(2'b00, 8'h01, 8'h01, 4'h0);
    send(2'b00, 8'h02, 8'h02, 4'h0);
    step();
    chk("mid_busy", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    chk("mrst_control", 32'(Control), 32'h6);
    chk("mrst_input1",  32'(Input_1), 32'h00);
    chk("mrst_input2",  32'(Input_2), 32'h00);
    chk("mrst_res",     32'(res), 32'h00);
    chk("mrst_ready",   32'(cmd_ready), 32'd1);
    chk("mrst_busy",    32'(busy), 32'd0);
    chk("mrst_done",    32'(done), 32'd0);
    d0 = done_cnt;
    step();
    RST = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("post_rst_res", 32'(res), 32'h00);
    chk("post_rst_control", 32'(Control), 32'h6);
    chk("post_rst_done_pulses", 32'(done_cnt - d0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
